sr_cmd_conditioner: RTL

- Upstream driver for the gated SR latch.
- Turns two raw, bouncy pushbutton inputs (set request, clear request) into clean, timed S/R/en commands for the latch.
- Synchronises and debounces each input, detects press edges, and queues one pending request per channel.
- Issues each request as a fixed-width enable pulse and never drives the forbidden S=R=1 combination.

---
 rtl/sr_cmd_conditioner.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/sr_cmd_conditioner.sv
// -----------------------------------------------------------------------------
// sr_cmd_conditioner
//
// Upstream driver for a gated SR latch. Two raw, bouncy pushbuttons (set
// request and clear request) are synchronised, debounced and edge-detected.
// Each press leaves one pending request per channel. A small FSM turns the
// pending requests into clean, timed S/R/en commands:
//   IDLE  -> pick a request, consume both flags, start a command
//   DRIVE -> en=1 with S/R held constant for EN_WIDTH cycles
//   GAP   -> one quiet cycle (S=R=en=0) before the next command
// The forbidden S=R=1 combination is never driven, and S/R are 0 whenever
// en is 0.
//
// Parameters:
//   DB_CYCLES  stable synchronised samples needed to move a debounced level
//              (1..255)
//   EN_WIDTH   cycles en is held high per command (1..15)
//   PRIORITY   both requests pending at issue time:
//              0 = clear wins, 1 = set wins, 2 = both dropped
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   rst       synchronous, active-high reset
//   set_btn   raw asynchronous set pushbutton, active high
//   clr_btn   raw asynchronous clear pushbutton, active high
//   S         set command to the latch (registered)
//   R         reset command to the latch (registered)
//   en        latch enable (registered)
//   busy      high while the FSM is in DRIVE or GAP (registered)
//   conflict  one-cycle pulse when both requests were pending at issue time
//
// Latency: a button held high from edge k (FSM idle) gives the first en=1
// cycle at edge k+DB_CYCLES+4 (2 sync + DB_CYCLES debounce + 1 pending +
// 1 issue).
//
// The FSM state is kept in the enum signal `state` so checkers can bind to it.
// -----------------------------------------------------------------------------
module sr_cmd_conditioner #(
  parameter int DB_CYCLES = 4,
  parameter int EN_WIDTH  = 2,
  parameter int PRIORITY  = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic set_btn,
  input  logic clr_btn,
  output logic S,
  output logic R,
  output logic en,
  output logic busy,
  output logic conflict
);

  // Channel index used throughout: bit 0 = set request, bit 1 = clear request.
  localparam int CH_SET = 0;
  localparam int CH_CLR = 1;

  // The counter update happens on the DB_CYCLES-th consecutive differing
  // sample, so the comparison is against DB_CYCLES-1.
  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);
  localparam logic [3:0] EN_LAST = 4'(EN_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state;

  // Input conditioning state.
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [7:0] db_cnt [2];
  logic [1:0] db_lvl;
  logic [1:0] db_prev;
  logic [1:0] pend;

  // DRIVE-phase cycle counter.
  logic [3:0] en_cnt;

  // Issue decision, evaluated only in IDLE.
  logic [1:0] rise;
  logic       both;
  logic       consume;
  logic       issue;
  logic       issue_s;
  logic       issue_r;

  // Press edges come from the debounced level, never the raw input; release
  // edges are ignored.
  assign rise = db_lvl & ~db_prev;
  assign both = pend[CH_SET] & pend[CH_CLR];

  always_comb begin
    consume = 1'b0;
    issue   = 1'b0;
    issue_s = 1'b0;
    issue_r = 1'b0;
    if (state == IDLE && (|pend)) begin
      // Both flags are always consumed together, whichever one wins.
      consume = 1'b1;
      if (both) begin
        if (PRIORITY == 0) begin
          issue   = 1'b1;
          issue_r = 1'b1;
        end else if (PRIORITY == 1) begin
          issue   = 1'b1;
          issue_s = 1'b1;
        end
        // Any other PRIORITY value drops both requests without a command.
      end else if (pend[CH_SET]) begin
        issue   = 1'b1;
        issue_s = 1'b1;
      end else begin
        issue   = 1'b1;
        issue_r = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      db_cnt   <= '{default: '0};
      db_lvl   <= '0;
      db_prev  <= '0;
      pend     <= '0;
      state    <= IDLE;
      en_cnt   <= '0;
      S        <= 1'b0;
      R        <= 1'b0;
      en       <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      // Two-flop synchroniser; only sync2 is used downstream.
      sync1 <= {clr_btn, set_btn};
      sync2 <= sync1;

      // Debounce: count consecutive samples that disagree with the current
      // level; any agreeing sample restarts the count, so short glitches
      // never move the level.
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_lvl[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
      db_prev <= db_lvl;

      // A press landing on the same edge the FSM consumes the flags must
      // survive, so new edges are ORed in after the consume.
      pend <= (consume ? 2'b00 : pend) | rise;

      conflict <= consume & both;

      case (state)
        IDLE: begin
          if (issue) begin
            state  <= DRIVE;
            en_cnt <= '0;
            S      <= issue_s;
            R      <= issue_r;
            en     <= 1'b1;
            busy   <= 1'b1;
          end
        end
        DRIVE: begin
          // S/R stay untouched here so they cannot change while en=1.
          if (en_cnt == EN_LAST) begin
            state <= GAP;
            S     <= 1'b0;
            R     <= 1'b0;
            en    <= 1'b0;
          end else begin
            en_cnt <= en_cnt + 4'd1;
          end
        end
        GAP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          S     <= 1'b0;
          R     <= 1'b0;
          en    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
